// File: rtl/filter_mult_sched_if.sv
// Handshake, multiplier and status signals of filter_mult_sched.
// The slave modport is the filter block; the master modport is its environment
// (sample producer, result consumer and the shared 2-cycle multiplier).
interface filter_mult_sched_if;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y_out;
    logic       mul_en;
    logic [7:0] mul_op1;
    logic [7:0] mul_op2;
    logic [7:0] mul_result;
    logic       busy;

    modport slave (
        input  clear, in_valid, x_in, out_ready, mul_result,
        output in_ready, out_valid, y_out, mul_en, mul_op1, mul_op2, busy
    );

    modport master (
        output clear, in_valid, x_in, out_ready, mul_result,
        input  in_ready, out_valid, y_out, mul_en, mul_op1, mul_op2, busy
    );
endinterface

// File: rtl/filter_mult_sched.sv
// Second-order recursive filter y_n = B*x_n + (A*B)*x_(n-1) + (A*A)*y_(n-2)
// evaluated term by term on one external shared 2-cycle multiplier.
// Strictly one sample in, one result out; history advances only on the
// output handshake.
// Optional feature: define SATURATE_OUT_EN to clamp y_out to 8'hFF when the
// 10-bit accumulator exceeds 255 (default build wraps modulo 256).
module filter_mult_sched #(
    parameter logic [7:0] A = 8'd2,
    parameter logic [7:0] B = 8'd3
) (
    input logic                 clk,
    input logic                 reset,
    filter_mult_sched_if.slave  fif
);
    // Products of two 8-bit constants, truncated to 8 bits.
    localparam logic [7:0] C_AB = 8'(A * B);
    localparam logic [7:0] C_AA = 8'(A * A);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TERM_BX  = 3'd1,
        TERM_ABX = 3'd2,
        TERM_AAY = 3'd3,
        OUT      = 3'd4
    } state_t;

    state_t      state_q;
    logic        phase_q;      // 0: first multiplier cycle, 1: second
    logic [9:0]  acc_q;
    logic [7:0]  xn_q;
    logic [7:0]  xnm1_q;
    logic [7:0]  ynm1_q;
    logic [7:0]  ynm2_q;
    logic [7:0]  y_out_q;
    logic        out_valid_q;
    logic        mul_en_q;
    logic [7:0]  mul_op1_q;
    logic [7:0]  mul_op2_q;

    logic [9:0]  acc_d;
    logic [7:0]  y_d;

    // Accumulator plus the product that completes this cycle, and the output value it maps to.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        acc_d = acc_q + {2'b00, fif.mul_result};
`ifdef SATURATE_OUT_EN
        y_d   = (acc_d > 10'd255) ? 8'hFF : acc_d[7:0];
`else
        y_d   = acc_d[7:0];
`endif
    end

    // Scheduler FSM: accept, three 2-cycle multiply terms, hold result until consumed.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!reset) begin
            state_q     <= IDLE;
            phase_q     <= 1'b0;
            acc_q       <= '0;
            xn_q        <= '0;
            xnm1_q      <= '0;
            ynm1_q      <= '0;
            ynm2_q      <= '0;
            y_out_q     <= '0;
            out_valid_q <= 1'b0;
            mul_en_q    <= 1'b0;
            mul_op1_q   <= '0;
            mul_op2_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (fif.clear) begin
                        xnm1_q <= '0;
                        ynm1_q <= '0;
                        ynm2_q <= '0;
                    end else if (fif.in_valid) begin
                        xn_q      <= fif.x_in;
                        acc_q     <= '0;
                        phase_q   <= 1'b0;
                        mul_en_q  <= 1'b1;
                        mul_op1_q <= B;
                        mul_op2_q <= fif.x_in;
                        state_q   <= TERM_BX;
                    end
                end
                TERM_BX: begin
                    phase_q <= ~phase_q;
                    if (phase_q) begin
                        acc_q     <= acc_d;
                        mul_op1_q <= C_AB;
                        mul_op2_q <= xnm1_q;
                        state_q   <= TERM_ABX;
                    end
                end
                TERM_ABX: begin
                    phase_q <= ~phase_q;
                    if (phase_q) begin
                        acc_q     <= acc_d;
                        mul_op1_q <= C_AA;
                        mul_op2_q <= ynm2_q;
                        state_q   <= TERM_AAY;
                    end
                end
                TERM_AAY: begin
                    phase_q <= ~phase_q;
                    if (phase_q) begin
                        acc_q       <= acc_d;
                        y_out_q     <= y_d;
                        out_valid_q <= 1'b1;
                        mul_en_q    <= 1'b0;
                        mul_op1_q   <= '0;
                        mul_op2_q   <= '0;
                        state_q     <= OUT;
                    end
                end
                OUT: begin
                    if (fif.out_ready) begin
                        ynm2_q      <= ynm1_q;
                        ynm1_q      <= y_out_q;
                        xnm1_q      <= xn_q;
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Ready is gated by reset and clear directly so it is low during reset and while clearing.
    assign fif.in_ready  = reset && (state_q == IDLE) && !fif.clear;
    assign fif.busy      = (state_q != IDLE);
    assign fif.out_valid = out_valid_q;
    assign fif.y_out     = y_out_q;
    assign fif.mul_en    = mul_en_q;
    assign fif.mul_op1   = mul_op1_q;
    assign fif.mul_op2   = mul_op2_q;
endmodule

// File: tb/tb_filter_mult_sched.sv
// Directed bench for filter_mult_sched with A=2, B=3 and a behavioural
// 2-cycle shared multiplier. Expected results are hand-computed.
module tb_filter_mult_sched;
    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    filter_mult_sched_if fif ();

    filter_mult_sched #(.A(8'd2), .B(8'd3)) dut (
        .clk   (clk),
        .reset (reset),
        .fif   (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared multiplier: operands registered on the first edge, product valid through the second cycle.
    logic [7:0] mul_p;
    always @(posedge clk) mul_p <= fif.mul_en ? 8'(fif.mul_op1 * fif.mul_op2) : 8'h00;
    assign fif.mul_result = mul_p;

`ifdef SATURATE_OUT_EN
    localparam logic [7:0] Y_BIG = 8'd255;
`else
    localparam logic [7:0] Y_BIG = 8'd224;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Offer x, follow the six multiply cycles, optionally stall the consumer, then hand-shake.
    task automatic send(input logic [7:0] x, input logic [7:0] y_exp, input int stall, input string tag);
        int waited = 0;
        logic [7:0] op_exp;
        while (!fif.in_ready && waited < 20) begin
            step();
            waited++;
        end
        check({tag, ".in_ready"}, fif.in_ready, 1);
        fif.in_valid = 1'b1;
        fif.x_in     = x;
        step();
        fif.in_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            op_exp = (c <= 2) ? 8'd3 : (c <= 4) ? 8'd6 : 8'd4;
            check($sformatf("%s.mul_en.c%0d", tag, c), fif.mul_en, 1);
            check($sformatf("%s.op1.c%0d", tag, c), fif.mul_op1, op_exp);
            check($sformatf("%s.out_valid.c%0d", tag, c), fif.out_valid, 0);
            step();
        end
        check({tag, ".out_valid.c7"}, fif.out_valid, 1);
        check({tag, ".y_out"}, fif.y_out, y_exp);
        check({tag, ".mul_en.c7"}, fif.mul_en, 0);
        for (int s = 0; s < stall; s++) begin
            step();
            check($sformatf("%s.stall%0d.y_out", tag, s), fif.y_out, y_exp);
            check($sformatf("%s.stall%0d.out_valid", tag, s), fif.out_valid, 1);
            check($sformatf("%s.stall%0d.in_ready", tag, s), fif.in_ready, 0);
            check($sformatf("%s.stall%0d.mul_en", tag, s), fif.mul_en, 0);
        end
        fif.out_ready = 1'b1;
        step();
        fif.out_ready = 1'b0;
        check({tag, ".out_valid.after"}, fif.out_valid, 0);
        check({tag, ".busy.after"}, fif.busy, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b0;
        fif.clear     = 1'b0;
        fif.in_valid  = 1'b0;
        fif.x_in      = 8'd0;
        fif.out_ready = 1'b0;
        step();
        step();
        step();
        check("rst.out_valid", fif.out_valid, 0);
        check("rst.y_out", fif.y_out, 0);
        check("rst.mul_en", fif.mul_en, 0);
        check("rst.op1", fif.mul_op1, 0);
        check("rst.op2", fif.mul_op2, 0);
        check("rst.busy", fif.busy, 0);
        check("rst.in_ready", fif.in_ready, 0);
        reset = 1'b1;
        #1;
        check("rst.in_ready_after", fif.in_ready, 1);

        // Basic recurrence: 3, 12, 24.
        send(8'd1, 8'd3, 0, "seq1");
        send(8'd2, 8'd12, 0, "seq2");
        send(8'd0, 8'd24, 0, "seq3");

        // Overflow: 240 + 240 = 480 saturates or wraps.
        do_reset();
        send(8'd40, 8'd120, 0, "ovf1");
        send(8'd80, Y_BIG, 0, "ovf2");

        // Consumer stall for 5 cycles.
        do_reset();
        send(8'd1, 8'd3, 5, "stall");

        // Reset in cycle 3 of a computation discards the sample.
        fif.in_valid = 1'b1;
        fif.x_in     = 8'd5;
        step();
        fif.in_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        check("midrst.out_valid", fif.out_valid, 0);
        check("midrst.busy", fif.busy, 0);
        check("midrst.mul_en", fif.mul_en, 0);
        check("midrst.op1", fif.mul_op1, 0);
        check("midrst.op2", fif.mul_op2, 0);
        check("midrst.y_out", fif.y_out, 0);
        check("midrst.in_ready", fif.in_ready, 0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("midrst.no_pulse%0d", i), fif.out_valid, 0);
        end
        send(8'd1, 8'd3, 0, "midrst.next");

        // Clear beats a simultaneous in_valid and zeroes history (else x=1 would give 27).
        send(8'd2, 8'd12, 0, "clr.pre");
        fif.clear    = 1'b1;
        fif.in_valid = 1'b1;
        fif.x_in     = 8'd9;
        #1;
        check("clr.in_ready", fif.in_ready, 0);
        step();
        check("clr.busy", fif.busy, 0);
        check("clr.mul_en", fif.mul_en, 0);
        fif.clear    = 1'b0;
        fif.in_valid = 1'b0;
        send(8'd1, 8'd3, 0, "clr.next");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/filter_mult_sched.md
FILTER_MULT_SCHED -- requirements
Module: filter_mult_sched

Interface
REQ-001 SHALL have parameter A, default 8'd2, feedback coefficient a.
REQ-002 SHALL have parameter B, default 8'd3, input coefficient b.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port clear  input  1  synchronous history clear, honoured in IDLE only.
REQ-006 SHALL have port in_valid  input  1  sample x_in offered.
REQ-007 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-008 SHALL have port x_in  input  8  input sample x_n.
REQ-009 SHALL have port out_valid  output  1  y_out holds a result.
REQ-010 SHALL have port out_ready  input  1  consumer takes y_out.
REQ-011 SHALL have port y_out  output  8  filter output y_n.
REQ-012 SHALL have port mul_en  output  1  enable to the shared 2-cycle multiplier.
REQ-013 SHALL have port mul_op1  output  8  multiplier constant operand.
REQ-014 SHALL have port mul_op2  output  8  multiplier data operand.
REQ-015 SHALL have port mul_result  input  8  multiplier product, 8-bit truncated.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL compute y_n = B*x_n + (A*B)*x_(n-1) + (A*A)*y_(n-2) on one shared multiplier; the constants A*A and A*B are truncated to 8 bits.
REQ-018 SHALL implement states IDLE, TERM_BX, TERM_ABX, TERM_AAY and OUT.
REQ-019 SHALL assert in_ready only in IDLE with clear low; an edge with in_valid & in_ready captures x_in and moves to TERM_BX.
REQ-020 SHALL occupy each TERM state for exactly 2 cycles, holding mul_en=1 and stable operands for both cycles: TERM_BX (B, x_n), TERM_ABX (A*B, x_(n-1)), TERM_AAY (A*A, y_(n-2)).
REQ-021 SHALL add mul_result into a 10-bit accumulator on the edge ending the second cycle of each TERM state; the accumulator is zeroed on acceptance.
REQ-022 SHALL, in IDLE and OUT, drive mul_en=0, mul_op1=0 and mul_op2=0.
REQ-023 SHALL assert out_valid in the 7th cycle after the acceptance edge (6 busy cycles), with y_out registered.
REQ-024 SHALL hold out_valid and y_out stable while out_ready is low.
REQ-025 SHALL, on the edge where out_valid & out_ready are both high, update history (y_(n-2)<=y_(n-1), y_(n-1)<=y_out, x_(n-1)<=x_n), deassert out_valid and return to IDLE.
REQ-026 SHALL take history updates only from the output handshake, so the ordering is strictly one sample in, one result out.
REQ-027 SHALL, with clear high in IDLE, zero x_(n-1), y_(n-1) and y_(n-2) and hold in_ready low; clear wins over a simultaneous in_valid; clear is ignored in all other states.

Reset
REQ-028 SHALL, on any edge with reset=0, force IDLE, zero the history registers, accumulator, y_out, out_valid, mul_en and the operands, and drive in_ready=0.
REQ-029 SHALL, when reset is asserted mid-computation, discard the pending sample with no out_valid pulse.
REQ-030 SHALL assert in_ready in the first cycle after reset deasserts.

Configuration
REQ-031 SHALL, with SATURATE_OUT_EN defined, set y_out to 8'hFF when accumulator > 255, else to accumulator[7:0].
REQ-032 SHALL, without SATURATE_OUT_EN, set y_out to accumulator[7:0] (wrap mod 256).
REQ-033 SHALL feed back the y_out value as produced (saturated or wrapped) into the history.

Verification
REQ-034 SHALL cover: from reset with A=2, B=3, x=1 then 2 then 0 -> y_out = 3, 12, 24.
REQ-035 SHALL cover: sample accepted at edge E0 -> mul_en high for cycles 1-6 with op1 sequence 3,3,6,6,4,4, and out_valid high in cycle 7.
REQ-036 SHALL cover: x=40 then x=80 -> second y_out = 255 with SATURATE_OUT_EN, 224 without.
REQ-037 SHALL cover: out_ready held low for 5 cycles after out_valid -> y_out stable, in_ready low, no mul_en, then one handshake.
REQ-038 SHALL cover: reset low in cycle 3 of computation -> no out_valid, all outputs zero, and the next x=1 yields 3.
REQ-039 SHALL cover: after y=3,12 apply clear with in_valid high -> sample not accepted; the next x=1 yields 3.
